icache_refill_unit: RTL and testbench
=====================================

ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 SHALL have parameter B, default 64, meaning L1I block size in bytes; a multiple of 8 and at least 16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning refill buffer entries; a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port CacheRepActive, input, 1, L1I replacement in progress.
REQ-006 SHALL have port Address, input, 32, miss PC.
REQ-007 SHALL have port RepReady, output, 1, RepWord valid for the cache this cycle.
REQ-008 SHALL have port RepWord, output, 64, refill beat to the cache.
REQ-009 SHALL have port MemReq, output, 1, block read request.
REQ-010 SHALL have port MemAddr, output, 32, block-aligned request address.
REQ-011 SHALL have port MemReqReady, input, 1, request accepted.
REQ-012 SHALL have port MemRValid, input, 1, read beat valid.
REQ-013 SHALL have port MemRData, input, 64, read beat data.
REQ-014 SHALL have port MemRReady, output, 1, unit can accept a beat.
REQ-015 SHALL have port RefillBusy, output, 1, high in any state other than IDLE.

Function
REQ-016 BEATS SHALL equal B/8; beat counters SHALL be $clog2(BEATS)+1 bits wide.
REQ-017 States SHALL be IDLE, REQ, FILL, DRAIN and DONE.
REQ-018 IDLE->REQ SHALL occur when CacheRepActive=1; on that edge MemAddr SHALL latch {Address[31:$clog2(B)], zeros}, and both counters SHALL clear.
REQ-019 In REQ, MemReq SHALL be 1 with MemAddr stable; on MemReqReady=1 the state SHALL go to FILL, and MemReq SHALL drop the next cycle.
REQ-020 A beat SHALL be accepted when MemRValid&MemRReady; it SHALL be pushed to the FIFO, and rx_count SHALL increment.
REQ-021 MemRReady SHALL be 1 only in FILL/DRAIN, FIFO not full and rx_count<BEATS; beats outside that window SHALL be ignored.
REQ-022 RepReady SHALL be FIFO non-empty & CacheRepActive & state==FILL; RepWord SHALL be the FIFO head (combinational).
REQ-023 A beat SHALL pop when RepReady=1 (the cache consumes every RepReady cycle); tx_count SHALL increment.
REQ-024 First RepReady SHALL occur no earlier than the cycle after the first beat is accepted (1-cycle buffer latency).
REQ-025 Simultaneous push and pop SHALL both take effect; a full FIFO SHALL accept a push only if it pops in the same cycle.
REQ-026 FILL->DONE SHALL occur when tx_count reaches BEATS; DONE->IDLE SHALL occur when CacheRepActive=0.
REQ-027 CacheRepActive falling in REQ or FILL (flush) SHALL go to DRAIN, holding MemReq in REQ until accepted; DRAIN SHALL discard beats until rx_count=BEATS, then flush the FIFO and go to IDLE.
REQ-028 A new CacheRepActive during DRAIN/DONE SHALL be serviced only after IDLE is re-entered.
REQ-029 Beats SHALL be delivered in address order, with beat 0 at offset 0.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, empty the FIFO and zero the counters; MemReq, MemRReady, RepReady and RefillBusy SHALL be 0, and MemAddr and RepWord SHALL be 0.
REQ-031 Reset mid-refill SHALL abandon the transfer; no RepReady SHALL occur until a new miss.

Structure
REQ-032 The state enum and BEAT_BYTES=8 SHALL live in the shared cache package.
REQ-033 The FIFO SHALL be sub-module icache_refill_fifo (parameterised width/depth, push/pop/full/empty, async active-low reset).

Verification
REQ-034 Back-to-back fill: miss at 0x0000_1234 with 8 beats on consecutive cycles -> MemAddr=0x0000_1200, and 8 RepReady pulses carry the data in order.
REQ-035 Grant delay: MemReqReady held low 5 cycles -> MemReq and MemAddr stay stable 5 cycles, then exactly one request is made.
REQ-036 Gappy memory: MemRValid pattern 1,0,0,1,… -> RepReady is never high with the FIFO empty, and DONE is reached after exactly 8 pops.
REQ-037 Flush: CacheRepActive drops after 3 pops -> RepReady is 0 immediately, the remaining 5 beats are absorbed, then IDLE with the FIFO empty.
REQ-038 Reset asserted during FILL -> all outputs are 0 in the same cycle, and the next miss refills correctly from beat 0.
REQ-039 Back-to-back misses: CacheRepActive re-asserted 1 cycle after DONE->IDLE -> a new MemReq is issued with the new aligned address.

Source files
------------

// File: rtl/icache_refill_unit_pkg.sv
// Shared L1I cache definitions: beat size and the refill-unit state encoding.
package icache_refill_unit_pkg;

    localparam int unsigned BEAT_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } refill_state_e;

endpackage

// File: rtl/icache_refill_fifo.sv
// Small synchronous FIFO that buffers memory read beats on their way to the L1I.
module icache_refill_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_clr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/icache_refill_unit.sv
// L1I refill engine: issues one block read per miss and streams the beats to the cache.
module icache_refill_unit
    import icache_refill_unit_pkg::*;
#(
    parameter int unsigned B          = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CacheRepActive,
    input  logic [31:0] Address,
    output logic        RepReady,
    output logic [63:0] RepWord,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemReqReady,
    input  logic        MemRValid,
    input  logic [63:0] MemRData,
    output logic        MemRReady,
    output logic        RefillBusy
);

    localparam int unsigned BEATS = B / BEAT_BYTES;
    localparam int unsigned CW    = $clog2(BEATS) + 1;
    localparam int unsigned OFF   = $clog2(B);

    refill_state_e r_state;
    refill_state_e w_next;
    logic [CW-1:0] r_rx_cnt;
    logic [CW-1:0] r_tx_cnt;
    logic [31:0]   r_addr;
    logic          r_req_pend;
    logic          w_start;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_clr;
    logic          w_full;
    logic          w_empty;
    logic          w_unused_addr_bits;

    assign w_unused_addr_bits = ^Address[OFF-1:0];

    // Beats arriving while draining are counted but never enter the buffer.
    assign MemRReady  = ((r_state == ST_FILL) || (r_state == ST_DRAIN)) && !w_full
                        && (r_rx_cnt < CW'(BEATS));
    assign w_accept   = MemRValid && MemRReady;
    assign w_push     = w_accept && (r_state == ST_FILL);
    assign RepReady   = !w_empty && CacheRepActive && (r_state == ST_FILL);
    assign w_pop      = RepReady;
    assign w_clr      = (r_state == ST_DRAIN);
    assign MemReq     = r_req_pend;
    assign MemAddr    = r_addr;
    assign RefillBusy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (CacheRepActive) begin
                    w_next  = ST_REQ;
                    w_start = 1'b1;
                end
            end
            ST_REQ: begin
                if (!CacheRepActive)  w_next = ST_DRAIN;
                else if (MemReqReady) w_next = ST_FILL;
            end
            ST_FILL: begin
                if (!CacheRepActive)                             w_next = ST_DRAIN;
                else if (w_pop && (r_tx_cnt == CW'(BEATS - 1)))  w_next = ST_DONE;
            end
            ST_DRAIN: begin
                if (r_rx_cnt == CW'(BEATS)) w_next = ST_IDLE;
            end
            ST_DONE: begin
                if (!CacheRepActive) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request stays pending until granted, even if the miss is flushed meanwhile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_addr     <= '0;
            r_req_pend <= 1'b0;
        end else if (w_start) begin
            r_rx_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_addr     <= {Address[31:OFF], {OFF{1'b0}}};
            r_req_pend <= 1'b1;
        end else begin
            if (w_accept)                  r_rx_cnt   <= r_rx_cnt + CW'(1);
            if (w_pop)                     r_tx_cnt   <= r_tx_cnt + CW'(1);
            if (r_req_pend && MemReqReady) r_req_pend <= 1'b0;
        end
    end

    icache_refill_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (MemRData),
        .o_data  (RepWord),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit: queue-based reference model, directed scenarios, random soak.
module tb_icache_refill_unit;

    localparam int B          = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int BEATS      = B / 8;

    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_FILL  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CacheRepActive = 1'b0;
    logic [31:0] Address = '0;
    logic        RepReady;
    logic [63:0] RepWord;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemReqReady = 1'b0;
    logic        MemRValid = 1'b0;
    logic [63:0] MemRData = '0;
    logic        MemRReady;
    logic        RefillBusy;

    always #5 clk = ~clk;

    icache_refill_unit #(.B(B), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .CacheRepActive (CacheRepActive),
        .Address        (Address),
        .RepReady       (RepReady),
        .RepWord        (RepWord),
        .MemReq         (MemReq),
        .MemAddr        (MemAddr),
        .MemReqReady    (MemReqReady),
        .MemRValid      (MemRValid),
        .MemRData       (MemRData),
        .MemRReady      (MemRReady),
        .RefillBusy     (RefillBusy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the refill unit
    int          ph = P_IDLE;
    logic [63:0] q[$];
    int          rx = 0, tx = 0;
    logic [31:0] maddr = '0;
    bit          pend = 1'b0;

    // Memory responder and cache stimulus knobs
    bit          mem_act = 1'b0;
    logic [31:0] mem_base = '0;
    int          mem_beat = 0, vcnt = 0, vmode = 0, grant_hold = 0;
    bit          rand_grant = 1'b0, auto_cra = 1'b0;

    // Statistics used by the directed scenarios
    int cyc = 0, pop_count = 0, acc_count = 0, grants = 0, mreq_cycles = 0;
    int first_pop = 0, last_pop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
        return {a, 32'h5EED_0000 | 32'(i)};
    endfunction

    function automatic bit exp_rready();
        return ((ph == P_FILL) || (ph == P_DRAIN)) && (q.size() < FIFO_DEPTH) && (rx < BEATS);
    endfunction

    function automatic bit exp_repready();
        return (q.size() > 0) && CacheRepActive && (ph == P_FILL);
    endfunction

    task automatic drive();
        if (auto_cra) begin
            if (ph == P_IDLE)                      CacheRepActive = ($urandom_range(0, 2) == 0);
            else if (ph == P_REQ || ph == P_FILL)  CacheRepActive = ($urandom_range(0, 59) != 0);
            else if (ph == P_DRAIN)                CacheRepActive = 1'($urandom_range(0, 1));
            else                                   CacheRepActive = ($urandom_range(0, 2) == 0);
            Address = $urandom;
        end
        MemReqReady = pend && (grant_hold == 0) && (!rand_grant || $urandom_range(0, 1) == 1);
        if (mem_act) begin
            if (vmode == 0)      MemRValid = 1'b1;
            else if (vmode == 1) MemRValid = (vcnt % 3 == 0);
            else                 MemRValid = 1'($urandom_range(0, 1));
            MemRData = beat_data(mem_base, mem_beat);
            vcnt++;
        end else begin
            // Stray beats are only offered when the unit must be refusing them.
            MemRValid = !exp_rready() && ($urandom_range(0, 3) == 0);
            MemRData  = {$urandom, $urandom};
        end
    endtask

    task automatic cycle();
        bit rr, rp, acc, grant, cra;
        logic [63:0] rd;
        logic [31:0] a;
        int old_rx, old_tx;
        rr = exp_rready();
        rp = exp_repready();
        chk("RefillBusy", 64'(RefillBusy), 64'(ph != P_IDLE));
        chk("MemReq", 64'(MemReq), 64'(pend));
        chk("MemAddr", 64'(MemAddr), 64'(maddr));
        chk("MemRReady", 64'(MemRReady), 64'(rr));
        chk("RepReady", 64'(RepReady), 64'(rp));
        if (rp) chk("RepWord", RepWord, beat_data(maddr, tx));
        acc = MemRValid && rr;
        grant = pend && MemReqReady;
        cra = CacheRepActive;
        rd = MemRData;
        a = Address;
        old_rx = rx;
        old_tx = tx;
        if (pend) mreq_cycles++;
        @(posedge clk);
        cyc++;
        if (rp) begin
            void'(q.pop_front());
            tx++;
            pop_count++;
            if (pop_count == 1) first_pop = cyc;
            last_pop = cyc;
        end
        if (acc) begin
            rx++;
            acc_count++;
            if (ph == P_FILL) q.push_back(rd);
            if (mem_act) begin
                mem_beat++;
                if (mem_beat == BEATS) mem_act = 1'b0;
            end
        end
        if (grant) begin
            pend = 1'b0;
            grants++;
            mem_act = 1'b1;
            mem_base = maddr;
            mem_beat = 0;
            vcnt = 0;
        end else if (pend && grant_hold > 0) begin
            grant_hold--;
        end
        if (ph == P_DRAIN) q.delete();
        if (ph == P_IDLE) begin
            if (cra) begin
                ph = P_REQ;
                maddr = a & ~32'(B - 1);
                rx = 0;
                tx = 0;
                pend = 1'b1;
                pop_count = 0;
                acc_count = 0;
            end
        end else if (ph == P_REQ) begin
            if (!cra)       ph = P_DRAIN;
            else if (grant) ph = P_FILL;
        end else if (ph == P_FILL) begin
            if (!cra)                             ph = P_DRAIN;
            else if (rp && old_tx == BEATS - 1)   ph = P_DONE;
        end else if (ph == P_DRAIN) begin
            if (old_rx == BEATS) ph = P_IDLE;
        end else begin
            if (!cra) ph = P_IDLE;
        end
        #1;
        drive();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        CacheRepActive = 1'b0;
        MemReqReady = 1'b0;
        MemRValid = 1'b0;
        #1;
        chk("rst_MemReq", 64'(MemReq), 64'd0);
        chk("rst_MemRReady", 64'(MemRReady), 64'd0);
        chk("rst_RepReady", 64'(RepReady), 64'd0);
        chk("rst_RefillBusy", 64'(RefillBusy), 64'd0);
        chk("rst_MemAddr", 64'(MemAddr), 64'd0);
        chk("rst_RepWord", RepWord, 64'd0);
        ph = P_IDLE;
        q.delete();
        rx = 0;
        tx = 0;
        maddr = '0;
        pend = 1'b0;
        mem_act = 1'b0;
        grant_hold = 0;
        @(posedge clk);
        #1;
        chk("rst_hold_busy", 64'(RefillBusy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        drive();
    endtask

    task automatic wait_ph(input int target, input int budget, input string nm);
        int n = 0;
        while (ph != target && n < budget) begin
            cycle();
            n++;
        end
        chk(nm, 64'(ph), 64'(target));
    endtask

    task automatic wait_pops(input int target, input int budget, input string nm);
        int n = 0;
        while (pop_count < target && n < budget) begin
            cycle();
            n++;
        end
        chk(nm, 64'(pop_count), 64'(target));
    endtask

    initial begin
        int g0;
        #2;
        do_reset();

        // Back-to-back fill of the block holding 0x1234
        Address = 32'h0000_1234;
        CacheRepActive = 1'b1;
        cycle();
        chk("b2b_memaddr", 64'(MemAddr), 64'h1200);
        wait_ph(P_DONE, 40, "b2b_done");
        chk("b2b_pops", 64'(pop_count), 64'd8);
        chk("b2b_pop_span", 64'(last_pop - first_pop), 64'd7);

        // Miss re-asserted one cycle after returning to idle
        CacheRepActive = 1'b0;
        cycle();
        g0 = grants;
        CacheRepActive = 1'b1;
        Address = 32'h0000_5678;
        cycle();
        chk("rearm_memaddr", 64'(MemAddr), 64'h5640);
        wait_ph(P_DONE, 40, "rearm_done");
        chk("rearm_grants", 64'(grants - g0), 64'd1);

        // Grant held off for five cycles
        CacheRepActive = 1'b0;
        cycle();
        grant_hold = 5;
        mreq_cycles = 0;
        g0 = grants;
        CacheRepActive = 1'b1;
        Address = 32'h8000_0FFF;
        cycle();
        chk("delay_memaddr", 64'(MemAddr), 64'h8000_0FC0);
        wait_ph(P_FILL, 20, "delay_fill");
        chk("delay_req_cycles", 64'(mreq_cycles), 64'd6);
        chk("delay_grants", 64'(grants - g0), 64'd1);
        wait_ph(P_DONE, 40, "delay_done");

        // Gappy memory 1,0,0,1,...
        CacheRepActive = 1'b0;
        cycle();
        vmode = 1;
        CacheRepActive = 1'b1;
        Address = 32'h0000_3000;
        cycle();
        wait_ph(P_DONE, 80, "gappy_done");
        chk("gappy_pops", 64'(pop_count), 64'd8);
        vmode = 0;

        // Flush after three pops
        CacheRepActive = 1'b0;
        cycle();
        CacheRepActive = 1'b1;
        Address = 32'h0001_0008;
        cycle();
        wait_pops(3, 40, "flush_three_pops");
        CacheRepActive = 1'b0;
        #1;
        chk("flush_repready", 64'(RepReady), 64'd0);
        wait_ph(P_IDLE, 40, "flush_idle");
        chk("flush_pops", 64'(pop_count), 64'd3);
        chk("flush_absorbed", 64'(acc_count), 64'd8);

        // Reset in the middle of a fill, then a clean refill
        CacheRepActive = 1'b1;
        Address = 32'h0000_2040;
        cycle();
        wait_pops(2, 40, "rst_mid_pops");
        do_reset();
        CacheRepActive = 1'b1;
        Address = 32'h0000_4444;
        cycle();
        chk("post_rst_memaddr", 64'(MemAddr), 64'h4440);
        wait_ph(P_DONE, 40, "post_rst_done");
        chk("post_rst_pops", 64'(pop_count), 64'd8);
        CacheRepActive = 1'b0;
        cycle();

        // Random soak
        auto_cra = 1'b1;
        vmode = 2;
        rand_grant = 1'b1;
        repeat (4000) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
